layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter DIM, default 26: spatial size of the transferred tensor, x and y each 0..DIM-1.
REQ-002 SHALL have parameter NUM_CH, default 16: channel count, c in 0..NUM_CH-1.
REQ-003 SHALL have parameter NUM_PASS, default 1: compute+transfer passes per start; legal range 1..255.
REQ-004 SHALL have parameter IDX_W, default 16: index width; DIM and NUM_CH are at most 2^IDX_W.
REQ-005 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: begin a run; sampled in IDLE only.
REQ-008 SHALL have port abort, input, 1: synchronous cancel of a run, any state.
REQ-009 SHALL have port mode, input, 1: 0 = x-fastest order (x, y, c); 1 = channel-fastest order (c, x, y); latched on accepted start.
REQ-010 SHALL have port compute_start, output, 1: one-cycle pulse requesting upstream compute.
REQ-011 SHALL have port compute_done, input, 1: upstream compute finished; sampled in WAIT only.
REQ-012 SHALL have ports idx_x, idx_y, idx_c, output, IDX_W each: current transfer address.
REQ-013 SHALL have port wr_valid, output, 1: the index is valid for a write into the next-layer input memory.
REQ-014 SHALL have port wr_ready, input, 1: memory accepts; a beat transfers when wr_valid && wr_ready.
REQ-015 SHALL have port pass_cnt, output, 8: index of the current pass, 0-based.
REQ-016 SHALL have ports busy and done, output, 1 each: busy is high outside IDLE; done is a one-cycle pulse at run completion.

Function
REQ-017 SHALL implement the states IDLE, REQ, WAIT, XFER, NEXT and FIN, held in a registered state encoding.
REQ-018 IDLE: start=1 SHALL latch mode, clear pass_cnt and the indices, and go to REQ; start in any other state SHALL be ignored.
REQ-019 REQ: compute_start SHALL be 1 for exactly this one cycle, then the state SHALL go to WAIT.
REQ-020 WAIT: compute_done=1 SHALL go to XFER with indices (0,0,0); compute_done outside WAIT SHALL be ignored.
REQ-021 XFER: wr_valid SHALL be 1, and the indices SHALL hold while wr_ready=0 (no beat skipped or repeated).
REQ-022 Mode 0, on each beat: x increments; x wraps from DIM-1 to 0 with y+1; y wraps from DIM-1 to 0 with c+1.
REQ-023 Mode 1, on each beat: c increments; c wraps from NUM_CH-1 to 0 with x+1; x wraps from DIM-1 to 0 with y+1.
REQ-024 The beat at the last index SHALL go to NEXT; the last index is (DIM-1, DIM-1, NUM_CH-1), either mode.
REQ-025 Exactly DIM*DIM*NUM_CH beats SHALL occur per pass, each (x,y,c) exactly once.
REQ-026 NEXT: indices SHALL return to 0 and wr_valid SHALL be 0.
REQ-027 NEXT: if pass_cnt==NUM_PASS-1, the state SHALL go to FIN; otherwise pass_cnt SHALL increment and the state SHALL go to REQ.
REQ-028 FIN: done SHALL pulse for one cycle, then the state SHALL return to IDLE; the simulation SHALL never be terminated.
REQ-029 abort=1 SHALL force IDLE next cycle from any state: wr_valid=0, indices=0, no done pulse.
REQ-030 abort SHALL take priority over start, compute_done and wr_ready in the same cycle.
REQ-031 wr_valid SHALL be a registered output and SHALL be 1 only in XFER.
REQ-032 compute_start SHALL be a registered output and SHALL be 1 only in REQ.
REQ-033 done SHALL be a registered output.
REQ-034 Index counters SHALL never exceed DIM-1 or NUM_CH-1; no wrap through 2^IDX_W.

Reset
REQ-035 reset=0 SHALL asynchronously force state IDLE.
REQ-036 reset=0 SHALL asynchronously force compute_start=0, wr_valid=0, done=0 and busy=0.
REQ-037 reset=0 SHALL asynchronously force idx_x=idx_y=idx_c=0, pass_cnt=0 and latched mode=0.
REQ-038 reset asserted mid-run SHALL abandon the run; after release the block SHALL wait for a new start.

Verification
REQ-039 DIM=2, NUM_CH=2, mode 0, wr_ready=1 -> compute_start once; after done, 8 beats in order (0,0,0),(1,0,0),(0,1,0),(1,1,0),(0,0,1),…,(1,1,1); done one cycle after NEXT.
REQ-040 Same config, mode 1 -> order (0,0,0),(0,0,1),(1,0,0),(1,0,1),(0,1,0),…,(1,1,1).
REQ-041 wr_ready toggled randomly -> indices stable while stalled; exactly DIM*DIM*NUM_CH accepted beats, no duplicates.
REQ-042 NUM_PASS=3 -> three compute_start pulses; pass_cnt 0,1,2; a single done after the third transfer.
REQ-043 abort in WAIT and again mid-XFER -> IDLE next cycle, wr_valid=0, no done; a subsequent start runs cleanly.
REQ-044 reset=0 asserted mid-XFER, between clock edges -> outputs zero immediately, no edge needed; start ignored while reset=0.

Source files
------------

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: compute handshake and next-layer write bus
interface layer_sequencer_if #(parameter int IDX_W = 16);
   logic             compute_start;
   logic             compute_done;
   logic             wr_valid;
   logic             wr_ready;
   logic [IDX_W-1:0] idx_x;
   logic [IDX_W-1:0] idx_y;
   logic [IDX_W-1:0] idx_c;
   modport master (
      output compute_start, wr_valid, idx_x, idx_y, idx_c,
      input  compute_done, wr_ready
   );
   modport slave (
      input  compute_start, wr_valid, idx_x, idx_y, idx_c,
      output compute_done, wr_ready
   );
endinterface

// File: rtl/layer_sequencer.sv
// layer_sequencer: per-pass compute request then ordered (x,y,c) write stream into the next layer
module layer_sequencer #(
   parameter int DIM      = 26,
   parameter int NUM_CH   = 16,
   parameter int NUM_PASS = 1,
   parameter int IDX_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic                mode,
   layer_sequencer_if.master   bus,
   output logic [7:0]          pass_cnt,
   output logic                busy,
   output logic                done
);
   localparam logic [IDX_W-1:0] X_MAX = IDX_W'(DIM - 1);
   localparam logic [IDX_W-1:0] C_MAX = IDX_W'(NUM_CH - 1);
   localparam logic [7:0]       P_MAX = 8'(NUM_PASS - 1);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, XFER, NEXT, FIN} state_t;
   state_t           state;
   logic             mode_q;
   logic             x_last, y_last, c_last, last;
   logic [IDX_W-1:0] nx, ny, nc;
   assign busy = state != IDLE;
   // next index after a beat; mode_q picks which counter runs fastest
   always_comb begin
      x_last = bus.idx_x == X_MAX;
      y_last = bus.idx_y == X_MAX;
      c_last = bus.idx_c == C_MAX;
      last   = x_last && y_last && c_last;
      nx = (mode_q ? c_last : 1'b1) ? (x_last ? '0 : bus.idx_x + IDX_W'(1)) : bus.idx_x;
      ny = (mode_q ? (c_last && x_last) : x_last) ? (y_last ? '0 : bus.idx_y + IDX_W'(1)) : bus.idx_y;
      nc = (mode_q ? 1'b1 : (x_last && y_last)) ? (c_last ? '0 : bus.idx_c + IDX_W'(1)) : bus.idx_c;
   end
   // run FSM; all handshake outputs are registered and set on entry to their state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= IDLE;
         mode_q            <= 1'b0;
         pass_cnt          <= '0;
         done              <= 1'b0;
         bus.compute_start <= 1'b0;
         bus.wr_valid      <= 1'b0;
         bus.idx_x         <= '0;
         bus.idx_y         <= '0;
         bus.idx_c         <= '0;
      end else if (abort) begin
         state             <= IDLE;
         done              <= 1'b0;
         bus.compute_start <= 1'b0;
         bus.wr_valid      <= 1'b0;
         bus.idx_x         <= '0;
         bus.idx_y         <= '0;
         bus.idx_c         <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state             <= REQ;
               mode_q            <= mode;
               pass_cnt          <= '0;
               bus.compute_start <= 1'b1;
               bus.idx_x         <= '0;
               bus.idx_y         <= '0;
               bus.idx_c         <= '0;
            end
            REQ: begin
               state             <= WAIT;
               bus.compute_start <= 1'b0;
            end
            WAIT: if (bus.compute_done) begin
               state        <= XFER;
               bus.wr_valid <= 1'b1;
               bus.idx_x    <= '0;
               bus.idx_y    <= '0;
               bus.idx_c    <= '0;
            end
            XFER: if (bus.wr_ready) begin
               state        <= last ? NEXT : XFER;
               bus.wr_valid <= !last;
               bus.idx_x    <= nx;
               bus.idx_y    <= ny;
               bus.idx_c    <= nc;
            end
            NEXT: if (pass_cnt == P_MAX) begin
               state <= FIN;
               done  <= 1'b1;
            end else begin
               state             <= REQ;
               pass_cnt          <= pass_cnt + 8'd1;
               bus.compute_start <= 1'b1;
            end
            FIN: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboard bench for layer_sequencer (DIM=3, NUM_CH=2, NUM_PASS=3)
module tb_layer_sequencer;
   localparam int DIM      = 3;
   localparam int NUM_CH   = 2;
   localparam int NUM_PASS = 3;
   localparam int TOTAL    = NUM_PASS * DIM * DIM * NUM_CH;
   logic       clk, reset, start, abort, mode;
   logic [7:0] pass_cnt;
   logic       busy, done;
   layer_sequencer_if #(.IDX_W(16)) bus();
   layer_sequencer #(.DIM(DIM), .NUM_CH(NUM_CH), .NUM_PASS(NUM_PASS), .IDX_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .mode(mode),
      .bus(bus), .pass_cnt(pass_cnt), .busy(busy), .done(done)
   );
   int          n_vec = 0, n_err = 0;
   logic [31:0] exp_q[$];
   bit          rdy_rand = 0, cd_force = 0, prev_cs = 0, prev_stall = 0;
   logic [47:0] prev_idx;
   int          cd_wait = 0, cs_cnt = 0, done_cnt = 0, since_last = 100;
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic push_exp(input logic m);
      for (int p = 0; p < NUM_PASS; p++)
         if (!m) begin
            for (int c = 0; c < NUM_CH; c++)
               for (int y = 0; y < DIM; y++)
                  for (int x = 0; x < DIM; x++)
                     exp_q.push_back({8'(p), 8'(x), 8'(y), 8'(c)});
         end else begin
            for (int y = 0; y < DIM; y++)
               for (int x = 0; x < DIM; x++)
                  for (int c = 0; c < NUM_CH; c++)
                     exp_q.push_back({8'(p), 8'(x), 8'(y), 8'(c)});
         end
   endtask
   task automatic cycle();
      logic [31:0] got;
      @(negedge clk);
      bus.wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.compute_start) begin
         cd_wait = 3;
         cs_cnt++;
      end else if (cd_wait > 0) cd_wait--;
      bus.compute_done = (cd_wait == 1) || cd_force;
      if (prev_cs) check("cs_width", 64'(bus.compute_start), 64'd0);
      if (prev_stall) check("stall_hold", {bus.wr_valid, bus.idx_x, bus.idx_y, bus.idx_c}, {1'b1, prev_idx});
      got = {pass_cnt, bus.idx_x[7:0], bus.idx_y[7:0], bus.idx_c[7:0]};
      if (bus.wr_valid && bus.wr_ready) begin
         if (exp_q.size() == 0) check("beat_extra", 64'(got), 64'hFFFF_FFFF);
         else begin
            check("beat", 64'(got), 64'(exp_q.pop_front()));
            if (exp_q.size() == 0) since_last = 0;
         end
      end
      if (done) begin
         done_cnt++;
         check("done_lat", 64'(since_last), 64'd2);
         check("done_q_empty", 64'(exp_q.size()), 64'd0);
      end
      since_last++;
      prev_cs    = bus.compute_start;
      prev_stall = bus.wr_valid && !bus.wr_ready;
      prev_idx   = {bus.idx_x, bus.idx_y, bus.idx_c};
   endtask
   task automatic begin_run(input logic m, input bit rnd);
      rdy_rand = rnd;
      cs_cnt   = 0;
      done_cnt = 0;
      start    = 1'b1;
      mode     = m;
      push_exp(m);
      cycle();
      start = 1'b0;
      mode  = ~m;
      check("busy_run", 64'(busy), 64'd1);
   endtask
   task automatic run(input logic m, input bit rnd);
      begin_run(m, rnd);
      for (int i = 0; i < 4000 && done_cnt == 0; i++) cycle();
      cycle();
      cycle();
      check("cs_pulses", 64'(cs_cnt), 64'(NUM_PASS));
      check("done_once", 64'(done_cnt), 64'd1);
      check("idle_after", {busy, bus.wr_valid}, 64'd0);
      check("q_left", 64'(exp_q.size()), 64'd0);
   endtask
   task automatic flush();
      exp_q.delete();
      prev_stall = 0;
      prev_cs    = 0;
      done_cnt   = 0;
   endtask
   initial begin
      reset = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      mode  = 1'b0;
      bus.wr_ready     = 1'b1;
      bus.compute_done = 1'b0;
      #1 reset = 1'b0;
      repeat (3) cycle();
      check("rst_out", {bus.compute_start, bus.wr_valid, done, busy, pass_cnt, bus.idx_x, bus.idx_y, bus.idx_c}, 64'd0);
      reset = 1'b1;
      cycle();
      cd_force = 1;
      cycle();
      cd_force = 0;
      cycle();
      check("cd_in_idle", {busy, bus.wr_valid}, 64'd0);
      start = 1'b1;
      abort = 1'b1;
      cycle();
      start = 1'b0;
      abort = 1'b0;
      cycle();
      check("abort_over_start", 64'(busy), 64'd0);
      run(1'b0, 0);
      run(1'b1, 0);
      run(1'b0, 1);
      run(1'b1, 1);
      begin_run(1'b0, 0);
      cycle();
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      check("abort_wait", {busy, bus.wr_valid, bus.compute_start}, 64'd0);
      flush();
      repeat (4) cycle();
      check("abort_wait_nodone", {done_cnt[7:0], busy}, 64'd0);
      begin_run(1'b1, 0);
      for (int i = 0; i < 500 && exp_q.size() > TOTAL - 7; i++) cycle();
      check("mid_xfer", 64'(bus.wr_valid), 64'd1);
      abort = 1'b1;
      cycle();
      abort = 1'b0;
      check("abort_xfer", {busy, bus.wr_valid, bus.idx_x, bus.idx_y, bus.idx_c}, 64'd0);
      flush();
      repeat (4) cycle();
      check("abort_xfer_nodone", {done_cnt[7:0], busy}, 64'd0);
      run(1'b0, 1);
      begin_run(1'b0, 0);
      for (int i = 0; i < 500 && exp_q.size() > TOTAL - 23; i++) cycle();
      check("mid_xfer2", {bus.wr_valid, pass_cnt}, {1'b1, 8'd1});
      #2 reset = 1'b0;
      #1 check("rst_async", {bus.compute_start, bus.wr_valid, done, busy, pass_cnt, bus.idx_x, bus.idx_y, bus.idx_c}, 64'd0);
      flush();
      start = 1'b1;
      repeat (3) cycle();
      check("rst_start_ignored", {busy, bus.compute_start}, 64'd0);
      start = 1'b0;
      reset = 1'b1;
      repeat (3) cycle();
      check("idle_post_rst", {busy, bus.compute_start, done_cnt[7:0]}, 64'd0);
      run(1'b1, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
